reg_bank_sb: RTL and testbench

//  Parametrised multi-read-port register bank with write-to-read bypass, per-register

---
 rtl/reg_bank_pkg.sv | 7 +
 rtl/reg_clear_seq.sv | 31 +++
 rtl/reg_bank_sb.sv | 62 ++++++
 tb/tb_reg_bank_sb.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared types and address check for the register bank
package reg_bank_pkg;
  typedef enum logic {ST_IDLE, ST_SWEEP} clr_state_t;
  function automatic logic addr_valid(input int addr, input int depth, input bit zero_reg);
    return (addr < depth) && !(zero_reg && addr == 0);
  endfunction
endpackage

// File: rtl/reg_clear_seq.sv
// reg_clear_seq: soft-clear sequencer sweeping one register per cycle
module reg_clear_seq
  import reg_bank_pkg::*;
#(
  parameter int DEPTH  = 14,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_idx
);
  clr_state_t st;
  logic last;
  assign last = clr_idx == ADDR_W'(DEPTH - 1);
  // clr is only looked at in IDLE, so a held clr restarts one cycle after a sweep ends
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= ST_IDLE;
      clr_idx <= '0;
    end else if (st == ST_IDLE) begin
      st <= clr ? ST_SWEEP : ST_IDLE;
    end else begin
      st <= last ? ST_IDLE : ST_SWEEP;
      clr_idx <= last ? '0 : clr_idx + 1'b1;
    end
  assign busy = st == ST_SWEEP;
  assign clr_we = busy;
endmodule

// File: rtl/reg_bank_sb.sv
// reg_bank_sb: multi-port register bank with write bypass, pending scoreboard and soft-clear
module reg_bank_sb
  import reg_bank_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 14,
  parameter int ADDR_W   = 4,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        addr_wr,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic [NUM_RD*ADDR_W-1:0] addr_rd,
  output logic [NUM_RD*DATA_W-1:0] data_out,
  output logic [NUM_RD-1:0]        pend_out,
  input  logic                     clr,
  output logic                     busy,
  output logic                     wr_err
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0] pend;
  logic clr_we, wr_ok, rsv_ok;
  logic [ADDR_W-1:0] clr_idx;
  reg_clear_seq #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_seq (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy), .clr_we(clr_we), .clr_idx(clr_idx)
  );
  assign wr_ok = we && !busy && addr_valid(int'(addr_wr), DEPTH, ZERO_REG != 0);
  assign rsv_ok = rsv_en && !busy && addr_valid(int'(rsv_addr), DEPTH, ZERO_REG != 0);
  // reservation is applied last so a same-cycle producer keeps the entry pending
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem <= '{default: '0};
      pend <= '0;
      wr_err <= 1'b0;
    end else begin
      wr_err <= we && !wr_ok;
      if (clr_we) begin
        mem[clr_idx] <= '0;
        pend[clr_idx] <= 1'b0;
      end
      if (wr_ok) begin
        mem[addr_wr] <= data_in;
        pend[addr_wr] <= 1'b0;
      end
      if (rsv_ok) pend[rsv_addr] <= 1'b1;
    end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic v;
    assign a = addr_rd[k*ADDR_W +: ADDR_W];
    assign v = addr_valid(int'(a), DEPTH, ZERO_REG != 0);
    assign data_out[k*DATA_W +: DATA_W] = !v ? '0 :
                                          (BYPASS != 0 && wr_ok && addr_wr == a) ? data_in : mem[a];
    assign pend_out[k] = v && pend[a];
  end
endmodule

// File: tb/tb_reg_bank_sb.sv
// tb_reg_bank_sb: directed self-checking bench for reg_bank_sb
module tb_reg_bank_sb;
  logic clk = 0, rst = 1, we = 0, rsv_en = 0, clr = 0;
  logic [3:0] addr_wr = 0, rsv_addr = 0;
  logic [15:0] data_in = 0;
  logic [7:0] addr_rd = 0;
  logic [31:0] data_out, data_out_z;
  logic [1:0] pend_out, pend_out_z;
  logic busy, wr_err, busy_z, wr_err_z;
  int checks = 0, errors = 0;

  reg_bank_sb dut (
    .clk(clk), .rst(rst), .we(we), .addr_wr(addr_wr), .data_in(data_in),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .addr_rd(addr_rd), .data_out(data_out),
    .pend_out(pend_out), .clr(clr), .busy(busy), .wr_err(wr_err)
  );
  reg_bank_sb #(.ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst), .we(we), .addr_wr(addr_wr), .data_in(data_in),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .addr_rd(addr_rd), .data_out(data_out_z),
    .pend_out(pend_out_z), .clr(clr), .busy(busy_z), .wr_err(wr_err_z)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12 rst = 0;
    tick();
    // 1: reset state on every address, including out-of-range codes
    for (int a = 0; a < 16; a++) begin
      addr_rd = {4'(a), 4'(a)};
      #1;
      chk($sformatf("rst_data_%0d", a), data_out, 32'h0);
      chk($sformatf("rst_pend_%0d", a), {30'h0, pend_out}, 32'h0);
    end
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_wr_err", {31'h0, wr_err}, 32'h0);
    // 2: same-cycle bypass, then held value
    addr_rd = {4'd0, 4'd3};
    we = 1; addr_wr = 3; data_in = 16'hA5A5;
    #1;
    chk("bypass_r3", data_out[15:0], 32'hA5A5);
    tick();
    we = 0;
    #1;
    chk("held_r3", data_out[15:0], 32'hA5A5);
    chk("r3_wr_err", {31'h0, wr_err}, 32'h0);
    // 3: reserve, then a write clears pending; pend is never bypassed
    rsv_en = 1; rsv_addr = 5;
    tick();
    rsv_en = 0; addr_rd = {4'd0, 4'd5};
    #1;
    chk("rsv_r5_pend", {30'h0, pend_out}, 32'h1);
    we = 1; addr_wr = 5; data_in = 16'h1234;
    #1;
    chk("r5_pend_not_bypassed", {30'h0, pend_out}, 32'h1);
    chk("r5_bypass", data_out[15:0], 32'h1234);
    tick();
    we = 0;
    #1;
    chk("r5_pend_cleared", {30'h0, pend_out}, 32'h0);
    chk("r5_data", data_out[15:0], 32'h1234);
    addr_rd = {4'd0, 4'd6};
    #1;
    chk("r6_before", data_out[15:0], 32'h0);
    we = 1; addr_wr = 6; data_in = 16'hBEEF; rsv_en = 1; rsv_addr = 6;
    tick();
    we = 0; rsv_en = 0;
    #1;
    chk("r6_rsv_wins_pend", {30'h0, pend_out}, 32'h1);
    chk("r6_data_written", data_out[15:0], 32'hBEEF);
    // 4: out-of-range write dropped with a one-cycle error pulse
    we = 1; addr_wr = 15; data_in = 16'h1111;
    tick();
    we = 0; addr_rd = {4'd15, 4'd3};
    #1;
    chk("oor_wr_err", {31'h0, wr_err}, 32'h1);
    chk("oor_r3_kept", data_out[15:0], 32'hA5A5);
    chk("oor_r15_reads0", data_out[31:16], 32'h0);
    tick();
    chk("oor_wr_err_drop", {31'h0, wr_err}, 32'h0);
    // ZERO_REG instance drops r0 writes; default instance accepts them
    we = 1; addr_wr = 0; data_in = 16'hFFFF; addr_rd = {4'd0, 4'd0};
    #1;
    chk("z_r0_no_bypass", data_out_z[15:0], 32'h0);
    tick();
    we = 0;
    #1;
    chk("z_r0_wr_err", {31'h0, wr_err_z}, 32'h1);
    chk("z_r0_reads0", data_out_z[15:0], 32'h0);
    chk("r0_written", data_out[15:0], 32'hFFFF);
    chk("r0_no_wr_err", {31'h0, wr_err}, 32'h0);
    // 5: fill, reserve two entries, sweep
    for (int k = 0; k < 14; k++) begin
      we = 1; addr_wr = 4'(k); data_in = 16'(k);
      tick();
    end
    we = 0;
    rsv_en = 1; rsv_addr = 2;
    tick();
    rsv_addr = 9;
    tick();
    rsv_en = 0; addr_rd = {4'd9, 4'd2};
    #1;
    chk("pre_sweep_pend", {30'h0, pend_out}, 32'h3);
    clr = 1;
    tick();
    clr = 0;
    for (int k = 0; k < 14; k++) begin
      addr_rd = {(k == 0) ? 4'd13 : (k == 3) ? 4'd12 : 4'(k - 1), 4'(k)};
      we = (k == 3); addr_wr = 12; data_in = 16'hDEAD;
      #1;
      chk($sformatf("sweep_busy_%0d", k), {31'h0, busy}, 32'h1);
      chk($sformatf("sweep_rk_%0d", k), data_out[15:0], 32'(k));
      chk($sformatf("sweep_prev_%0d", k), data_out[31:16],
          (k == 0) ? 32'hD : (k == 3) ? 32'hC : 32'h0);
      if (k == 4) chk("sweep_wr_err", {31'h0, wr_err}, 32'h1);
      tick();
    end
    we = 0;
    chk("sweep_done_busy", {31'h0, busy}, 32'h0);
    for (int a = 0; a < 14; a++) begin
      addr_rd = {4'(a), 4'(a)};
      #1;
      chk($sformatf("post_sweep_data_%0d", a), data_out, 32'h0);
      chk($sformatf("post_sweep_pend_%0d", a), {30'h0, pend_out}, 32'h0);
    end
    // held clr: ignored on the return cycle, restarts the following one
    clr = 1;
    tick();
    chk("hold_busy_start", {31'h0, busy}, 32'h1);
    repeat (13) tick();
    chk("hold_busy_last", {31'h0, busy}, 32'h1);
    tick();
    chk("hold_idle_gap", {31'h0, busy}, 32'h0);
    tick();
    chk("hold_restart", {31'h0, busy}, 32'h1);
    clr = 0;
    repeat (14) tick();
    chk("hold_end_busy", {31'h0, busy}, 32'h0);
    // 6: asynchronous reset in the middle of a sweep
    we = 1; addr_wr = 1; data_in = 16'h0101;
    tick();
    addr_wr = 13; data_in = 16'h0D0D;
    tick();
    we = 0; rsv_en = 1; rsv_addr = 13;
    tick();
    rsv_en = 0; addr_rd = {4'd1, 4'd13};
    #1;
    chk("pre_rst_r13", data_out[15:0], 32'h0D0D);
    chk("pre_rst_pend13", {31'h0, pend_out[0]}, 32'h1);
    clr = 1;
    tick();
    clr = 0;
    repeat (5) tick();
    chk("mid_sweep_busy", {31'h0, busy}, 32'h1);
    chk("mid_sweep_r13", data_out[15:0], 32'h0D0D);
    #1 rst = 1;
    #1;
    chk("arst_busy", {31'h0, busy}, 32'h0);
    chk("arst_data", data_out, 32'h0);
    chk("arst_pend", {30'h0, pend_out}, 32'h0);
    #1 rst = 0;
    we = 1; addr_wr = 7; data_in = 16'h7777; addr_rd = {4'd0, 4'd7};
    tick();
    we = 0;
    #1;
    chk("post_rst_r7", data_out[15:0], 32'h7777);
    chk("post_rst_wr_err", {31'h0, wr_err}, 32'h0);
    chk("post_rst_busy", {31'h0, busy}, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
